apb_master_bridge: RTL and testbench

Single-outstanding APB4 master that turns a valid/ready native command stream into APB4 transfers and returns each completion on a valid/ready response channel. It sits directly upstream of the APB slave adapter in peripheral subsystems: its APB outputs drive paddr/psel/penable/pwrite/pwdata/pstrb/pprot of the slave side, and it consumes prdata/pready/pslverr. It is the standard way for a CPU-side or DMA-side agent to reach APB register blocks.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_wait_timer.sv | 31 +++
 rtl/apb_master_bridge.sv | 111 +++++++++++
 tb/tb_apb_master_bridge.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM state encoding, PPROT bit positions, strobe-width helper.
// Pure declarations; no latency or flow control of its own.
// Imported by apb_master_bridge and apb_wait_timer.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    localparam int PPROT_PRIV   = 0;
    localparam int PPROT_NONSEC = 1;
    localparam int PPROT_INSTR  = 2;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait-state counter; expired is high while the count equals limit.
// Latency: counts on the cycle after count_en; expired is combinational from the count.
// Backpressure: none; saturates at limit until clear.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             pclk,
    input  logic             prst,
    input  logic             clear,
    input  logic             count_en,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    assign expired = (cnt == limit);

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 master: valid/ready command in, APB4 transfer out, valid/ready response back.
// Latency: accept at edge N -> SETUP N+1, ACCESS N+2, rsp_valid N+3 plus one cycle per wait state.
// Backpressure: cmd_ready only in IDLE or when a pending response is consumed; APB_MASTER_TIMEOUT_EN adds a wait limit.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             pclk,
    input  logic                             prst,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0] cmd_strb,
    input  logic [2:0]                       cmd_prot,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [2:0]                       pprot,
    output logic                             psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic [strb_width(DATA_WIDTH)-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0]            prdata,
    input  logic                             pready,
    input  logic                             pslverr,
    output logic                             timeout,
    output logic                             busy
);

    apb_mst_state_e state, state_nxt;
    logic           accept;
    logic           expired;

    assign cmd_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic timer_expired;

    // Cleared while in SETUP so the count starts at zero on ACCESS entry.
    apb_wait_timer #(.WIDTH(TW)) u_wait_timer (
        .pclk     (pclk),
        .prst     (prst),
        .clear    (state == SETUP),
        .count_en ((state == ACCESS) && !pready),
        .limit    (TW'(TIMEOUT_CYCLES)),
        .expired  (timer_expired)
    );

    // pready wins over a simultaneous limit hit.
    assign expired = timer_expired && (state == ACCESS) && !pready;
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready || expired) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = cmd_valid ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= '0;
            pprot     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            psel      <= (state_nxt == SETUP) || (state_nxt == ACCESS);
            penable   <= (state_nxt == ACCESS);
            rsp_valid <= (state_nxt == RESP);
            timeout   <= expired;
            if (accept) begin
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
                pwrite <= cmd_write;
                pprot  <= cmd_prot;
                pstrb  <= cmd_write ? cmd_strb : '0;
            end
            if ((state == ACCESS) && (pready || expired)) begin
                rsp_rdata <= (pready && !pwrite) ? prdata : '0;
                rsp_err   <= pready ? pslverr : 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboarded bench for apb_master_bridge: directed cases plus random traffic against a transaction-level model.
// Timeout expectations follow APB_MASTER_TIMEOUT_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          prst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;
    logic          timeout;
    logic          busy;

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .prst(prst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .timeout(timeout), .busy(busy)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        logic [DW-1:0] rdata;
        logic          err;
        int            waits;
        int            acc_cyc;
        int            rsp_cyc;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic          exp_to;
    } txn_t;

    txn_t apb_q[$];
    txn_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   hold_lo = 0;
    bit   rnd_rdy = 1'b0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // APB slave: waits t.waits cycles in ACCESS, then completes with the planned data.
    txn_t cur;
    bit   cur_vld = 1'b0;
    int   wcnt = 0;
    always @(negedge pclk) begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom);
        if (psel && !penable) begin
            if (apb_q.size() == 0) begin
                chk("unexpected_setup", 1, 0);
            end else begin
                cur = apb_q.pop_front();
                cur_vld = 1'b1;
                wcnt = 0;
                chk("setup_cycle", cyc, cur.acc_cyc + 1);
                chk("setup_req", {paddr, pwrite, pstrb, pprot, 24'h0},
                    {cur.addr, cur.write, (cur.write ? cur.strb : 4'h0), cur.prot, 24'h0});
                chk("setup_wdata", pwdata, cur.wdata);
            end
        end else if (psel && penable && cur_vld) begin
            if (wcnt == 0) chk("access_cycle", cyc, cur.acc_cyc + 2);
            chk("access_hold", {paddr, pwrite, pstrb, pprot, 24'h0},
                {cur.addr, cur.write, (cur.write ? cur.strb : 4'h0), cur.prot, 24'h0});
            if (wcnt == cur.waits) begin
                pready  = 1'b1;
                prdata  = cur.rdata;
                pslverr = cur.err;
                cur_vld = 1'b0;
            end
            wcnt++;
        end
    end

    always @(negedge pclk) begin
        if (hold_lo > 0) begin
            rsp_ready = 1'b0;
            hold_lo--;
        end else begin
            rsp_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Response monitor.
    bit   prev_pending = 1'b0;
    int   rsp_seen = 0;
    txn_t e;
    always @(negedge pclk) begin
        #3;
        if (prst) begin
            prev_pending = 1'b0;
        end else if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = rsp_q[0];
                if (!prev_pending) begin
                    chk("rsp_cycle", cyc, e.rsp_cyc);
                    chk("timeout_pulse", timeout, e.exp_to);
                end else begin
                    chk("timeout_low", timeout, 0);
                end
                chk("rsp_data", {rsp_rdata, rsp_err}, {e.exp_rdata, e.exp_err});
                if (!rsp_ready) chk("cmd_ready_blocked", cmd_ready, 0);
                if (rsp_ready) begin
                    void'(rsp_q.pop_front());
                    rsp_seen++;
                    prev_pending = 1'b0;
                end else begin
                    prev_pending = 1'b1;
                end
            end
        end else begin
            prev_pending = 1'b0;
            chk("timeout_idle", timeout, 0);
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [SW-1:0] s, input logic [2:0] p, input logic [DW-1:0] rd,
                        input logic er, input int waits, output int acc);
        txn_t t;
        int   eff;
        t.write = w; t.addr = a; t.wdata = wd; t.strb = s; t.prot = p;
        t.rdata = rd; t.err = er; t.waits = waits;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_strb = s; cmd_prot = p;
        #2;
        for (int n = 0; n < 300 && !cmd_ready; n++) begin
            @(negedge pclk);
            #2;
        end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        // Model: slave completes after 'waits' idle cycles unless the wait limit cuts it short.
        t.exp_to    = TO_EN && (waits > TO);
        eff         = t.exp_to ? TO : waits;
        t.acc_cyc   = cyc;
        t.rsp_cyc   = cyc + 3 + eff;
        t.exp_rdata = (t.exp_to || w) ? '0 : rd;
        t.exp_err   = t.exp_to ? 1'b1 : er;
        acc = cyc;
        apb_q.push_back(t);
        rsp_q.push_back(t);
        @(posedge pclk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_rand(input int waits);
        int acc;
        send(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom), $urandom,
             ($urandom_range(0, 3) == 0), waits, acc);
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && rsp_q.size() > 0; n++) @(negedge pclk);
        chk("drain", rsp_q.size(), 0);
    endtask

    task automatic reset_now();
        prst = 1'b1;
        #1;
        chk("rst_apb", {psel, penable}, 2'b00);
        chk("rst_rsp", {rsp_valid, busy, timeout}, 3'b000);
        chk("rst_cmd_ready", cmd_ready, 1);
        apb_q.delete();
        rsp_q.delete();
        cmd_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        prst = 1'b0;
    endtask

    int acc0, acc1, acc2, acc3;
    int seen_before;

    initial begin
        #12;
        chk("reset_ctrl", {psel, penable, pwrite, rsp_valid, rsp_err, timeout, busy}, 7'b0);
        chk("reset_data", {paddr, pwdata}, 64'h0);
        chk("reset_misc", {pstrb, pprot, rsp_rdata}, 39'h0);
        chk("reset_cmd_ready", cmd_ready, 1);
        @(negedge pclk);
        prst = 1'b0;

        // Basic write, zero wait states.
        send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'((1 << PPROT_PRIV) | (1 << PPROT_NONSEC)),
             32'h1234_5678, 1'b0, 0, acc0);
        drain();
        // Read with two wait states.
        send(1'b0, 32'h20, 32'h0, 4'hF, 3'(1 << PPROT_INSTR), 32'hA5A5_0001, 1'b0, 2, acc0);
        drain();
        // Slave error, then a clean write.
        send(1'b1, 32'h30, 32'h1, 4'h3, 3'h0, 32'h0, 1'b1, 1, acc0);
        send(1'b1, 32'h34, 32'h2, 4'hC, 3'h0, 32'h0, 1'b0, 0, acc0);
        drain();

        // Back-to-back with rsp_ready held high.
        send(1'b1, 32'h40, $urandom, 4'hF, 3'h0, 32'h0, 1'b0, 0, acc0);
        send(1'b0, 32'h44, $urandom, 4'hF, 3'h0, $urandom, 1'b0, 0, acc1);
        send(1'b1, 32'h48, $urandom, 4'h1, 3'h0, 32'h0, 1'b0, 0, acc2);
        send(1'b0, 32'h4C, $urandom, 4'hF, 3'h0, $urandom, 1'b0, 0, acc3);
        chk("b2b_gap1", acc1 - acc0, 3);
        chk("b2b_gap2", acc2 - acc1, 3);
        chk("b2b_gap3", acc3 - acc2, 3);
        drain();

        // Response stalled by rsp_ready low while the next command waits.
        send(1'b0, 32'h50, 32'h0, 4'hF, 3'h0, 32'hCAFE_0050, 1'b0, 0, acc0);
        hold_lo = 8;
        send(1'b1, 32'h54, 32'h55, 4'hF, 3'h0, 32'h0, 1'b0, 0, acc1);
        chk("stall_accept", acc1 - acc0, 9);
        drain();

        // Limit boundary: exactly TO wait states still completes normally.
        send(1'b0, 32'h60, 32'h0, 4'hF, 3'h0, 32'h6060_6060, 1'b0, TO, acc0);
        drain();
`ifdef APB_MASTER_TIMEOUT_EN
        send(1'b0, 32'h64, 32'h0, 4'hF, 3'h0, 32'h6464_6464, 1'b0, 1000000, acc0);
        drain();
        send(1'b1, 32'h68, 32'h68, 4'hF, 3'h0, 32'h0, 1'b0, 0, acc0);
        drain();
`else
        send(1'b0, 32'h64, 32'h0, 4'hF, 3'h0, 32'h6464_6464, 1'b0, 1000000, acc0);
        repeat (1000) @(posedge pclk);
        @(negedge pclk);
        #1;
        chk("stuck_in_access", {busy, psel, penable}, 3'b111);
        @(posedge pclk);
        #3;
        reset_now();
`endif

        // Reset during ACCESS discards the transfer.
        seen_before = rsp_seen;
        send(1'b0, 32'h70, 32'h0, 4'hF, 3'h0, 32'h7070_7070, 1'b0, 3, acc0);
        @(posedge pclk);
        #3;
        chk("pre_rst_access", {psel, penable}, 2'b11);
        reset_now();
        repeat (6) @(negedge pclk);
        chk("rst_no_rsp", rsp_seen, seen_before);
        send(1'b1, 32'h74, 32'h7474, 4'h5, 3'h0, 32'h0, 1'b0, 1, acc0);
        drain();

        // Random traffic with random response backpressure.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 40; i++) send_rand($urandom_range(0, 6));
        drain();
        rnd_rdy = 1'b0;
        chk("apb_q_empty", apb_q.size(), 0);

        repeat (3) @(negedge pclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got time %0t required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
